slave_port_arbiter: RTL and testbench

SLAVE_PORT_ARBITER -- requirements
Module: slave_port_arbiter

---
 rtl/slave_port_arbiter_if.sv | 43 ++++
 rtl/slave_port_arbiter.sv | 110 +++++++++++
 tb/tb_slave_port_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/slave_port_arbiter_if.sv
// Two-master / one-slave request bus seen by the slave port arbiter.
// The arbiter uses the slave modport; the master modport is the masters' and slave's side.
interface slave_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  m0_req;
  logic                  m1_req;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic                  m0_cmd;
  logic                  m1_cmd;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m0_ack;
  logic                  m1_ack;
  logic                  m0_resp;
  logic                  m1_resp;
  logic [DATA_WIDTH-1:0] m0_rdata;
  logic [DATA_WIDTH-1:0] m1_rdata;
  logic                  s_req;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic                  s_cmd;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  s_ack;
  logic                  s_resp;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            grant;

  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_cmd, m1_cmd, m0_wdata, m1_wdata,
    output m0_ack, m1_ack, m0_resp, m1_resp, m0_rdata, m1_rdata,
    output s_req, s_addr, s_cmd, s_wdata, grant,
    input  s_ack, s_resp, s_rdata
  );

  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_cmd, m1_cmd, m0_wdata, m1_wdata,
    input  m0_ack, m1_ack, m0_resp, m1_resp, m0_rdata, m1_rdata,
    input  s_req, s_addr, s_cmd, s_wdata, grant,
    output s_ack, s_resp, s_rdata
  );
endinterface

// File: rtl/slave_port_arbiter.sv
// Round-robin arbiter sharing one slave port between two masters.
// Request fields are registered on grant; ack/resp are steered back combinationally.
module slave_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  slave_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RESP} state_t;

  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  s_req_q, s_req_d;
  logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
  logic                  s_cmd_q, s_cmd_d;
  logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;
  logic [1:0]            grant_q, grant_d;
  logic                  win1;

  // State and registered slave-side request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      s_req_q   <= 1'b0;
      s_addr_q  <= '0;
      s_cmd_q   <= 1'b0;
      s_wdata_q <= '0;
      grant_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      s_req_q   <= s_req_d;
      s_addr_q  <= s_addr_d;
      s_cmd_q   <= s_cmd_d;
      s_wdata_q <= s_wdata_d;
      grant_q   <= grant_d;
    end
  end

  // Next-state: arbitrate only in IDLE; pointer flips to the loser on completion
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    s_req_d   = s_req_q;
    s_addr_d  = s_addr_q;
    s_cmd_d   = s_cmd_q;
    s_wdata_d = s_wdata_q;
    grant_d   = grant_q;
    win1      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          win1      = bus.m1_req && (!bus.m0_req || ptr_q);
          grant_d   = win1 ? 2'b10 : 2'b01;
          s_addr_d  = win1 ? bus.m1_addr : bus.m0_addr;
          s_cmd_d   = win1 ? bus.m1_cmd : bus.m0_cmd;
          s_wdata_d = win1 ? bus.m1_wdata : bus.m0_wdata;
          s_req_d   = 1'b1;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.s_ack) begin
          s_req_d = 1'b0;
          if (s_cmd_q) begin
            state_d = IDLE;
            grant_d = 2'b00;
            ptr_d   = grant_q[0];
          end else begin
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (bus.s_resp) begin
          state_d = IDLE;
          grant_d = 2'b00;
          ptr_d   = grant_q[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic ack_en_c, resp_en_c, m0_resp_c, m1_resp_c;

  // Gated by rst so an aborted transaction never reports back to a master
  assign ack_en_c  = (state_q == WAIT_ACK)  && bus.s_ack  && !rst;
  assign resp_en_c = (state_q == WAIT_RESP) && bus.s_resp && !rst;
  assign m0_resp_c = resp_en_c && grant_q[0];
  assign m1_resp_c = resp_en_c && grant_q[1];

  assign bus.m0_ack   = ack_en_c && grant_q[0];
  assign bus.m1_ack   = ack_en_c && grant_q[1];
  assign bus.m0_resp  = m0_resp_c;
  assign bus.m1_resp  = m1_resp_c;
  assign bus.m0_rdata = m0_resp_c ? bus.s_rdata : '0;
  assign bus.m1_rdata = m1_resp_c ? bus.s_rdata : '0;

  assign bus.s_req   = s_req_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_cmd   = s_cmd_q;
  assign bus.s_wdata = s_wdata_q;
  assign bus.grant   = grant_q;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Directed bench for slave_port_arbiter: writes, round-robin, reads, spurious slave
// handshakes and mid-transaction reset, each checked against hand-computed values.
module tb_slave_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  slave_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  slave_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow after #2
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    bus.m0_req = 0; bus.m1_req = 0;
    bus.m0_addr = '0; bus.m1_addr = '0;
    bus.m0_cmd = 0; bus.m1_cmd = 0;
    bus.m0_wdata = '0; bus.m1_wdata = '0;
    bus.s_ack = 0; bus.s_resp = 0; bus.s_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    clear_inputs();
    do_reset();
    settle();
    // Reset state
    chk("rst_grant", 64'(bus.grant), 64'h0);
    chk("rst_s_req", 64'(bus.s_req), 64'h0);
    chk("rst_s_addr", 64'(bus.s_addr), 64'h0);
    chk("rst_s_wdata", 64'(bus.s_wdata), 64'h0);
    chk("rst_acks", 64'({bus.m0_ack, bus.m1_ack, bus.m0_resp, bus.m1_resp}), 64'h0);

    // m0 write 0x10/0xA5, slave acks two cycles after s_req
    bus.m0_req = 1; bus.m0_addr = 32'h10; bus.m0_cmd = 1; bus.m0_wdata = 32'hA5;
    settle();
    chk("w_s_req_idle", 64'(bus.s_req), 64'h0);
    tick(); settle();
    chk("w_s_req", 64'(bus.s_req), 64'h1);
    chk("w_s_addr", 64'(bus.s_addr), 64'h10);
    chk("w_s_wdata", 64'(bus.s_wdata), 64'hA5);
    chk("w_s_cmd", 64'(bus.s_cmd), 64'h1);
    chk("w_grant", 64'(bus.grant), 64'h1);
    chk("w_m0_ack_early", 64'(bus.m0_ack), 64'h0);
    tick(); settle();
    chk("w_s_req_hold", 64'(bus.s_req), 64'h1);
    tick();
    bus.s_ack = 1;
    settle();
    chk("w_m0_ack", 64'(bus.m0_ack), 64'h1);
    chk("w_m1_ack", 64'(bus.m1_ack), 64'h0);
    tick();
    bus.s_ack = 0; bus.m0_req = 0;
    settle();
    chk("w_done_s_req", 64'(bus.s_req), 64'h0);
    chk("w_done_grant", 64'(bus.grant), 64'h0);
    chk("w_done_ack", 64'(bus.m0_ack), 64'h0);

    // Both masters request and hold: m0, m1, m0 with a zero-wait slave
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 32'h100; bus.m0_cmd = 1; bus.m0_wdata = 32'h11;
    bus.m1_req = 1; bus.m1_addr = 32'h200; bus.m1_cmd = 1; bus.m1_wdata = 32'h22;
    tick();
    bus.s_ack = 1;
    settle();
    chk("rr1_grant", 64'(bus.grant), 64'h1);
    chk("rr1_s_addr", 64'(bus.s_addr), 64'h100);
    chk("rr1_acks", 64'({bus.m1_ack, bus.m0_ack}), 64'h1);
    tick();
    bus.s_ack = 0;
    settle();
    chk("rr1_idle_grant", 64'(bus.grant), 64'h0);
    tick();
    bus.s_ack = 1;
    settle();
    chk("rr2_grant", 64'(bus.grant), 64'h2);
    chk("rr2_s_addr", 64'(bus.s_addr), 64'h200);
    chk("rr2_s_wdata", 64'(bus.s_wdata), 64'h22);
    chk("rr2_acks", 64'({bus.m1_ack, bus.m0_ack}), 64'h2);
    tick();
    bus.s_ack = 0;
    settle();
    tick();
    bus.s_ack = 1;
    settle();
    chk("rr3_grant", 64'(bus.grant), 64'h1);
    chk("rr3_s_addr", 64'(bus.s_addr), 64'h100);
    chk("rr3_acks", 64'({bus.m1_ack, bus.m0_ack}), 64'h1);
    tick();
    bus.s_ack = 0; bus.m0_req = 0; bus.m1_req = 0;
    settle();
    chk("rr_end_grant", 64'(bus.grant), 64'h0);

    // m1 read 0x20; s_resp alongside s_ack ignored, real s_resp three cycles later
    bus.m1_req = 1; bus.m1_addr = 32'h20; bus.m1_cmd = 0;
    tick();
    bus.s_ack = 1; bus.s_resp = 1; bus.s_rdata = 32'hDEAD_BEEF;
    settle();
    chk("rd_grant", 64'(bus.grant), 64'h2);
    chk("rd_s_cmd", 64'(bus.s_cmd), 64'h0);
    chk("rd_m1_ack", 64'(bus.m1_ack), 64'h1);
    chk("rd_resp_with_ack", 64'(bus.m1_resp), 64'h0);
    chk("rd_rdata_with_ack", 64'(bus.m1_rdata), 64'h0);
    tick();
    bus.s_ack = 0; bus.s_resp = 0; bus.m1_req = 0;
    settle();
    chk("rd_wr_s_req", 64'(bus.s_req), 64'h0);
    chk("rd_wr_grant", 64'(bus.grant), 64'h2);
    chk("rd_wr_rdata_gated", 64'(bus.m1_rdata), 64'h0);
    tick();
    bus.s_ack = 1;
    settle();
    chk("rd_spurious_ack", 64'({bus.m1_ack, bus.m0_ack}), 64'h0);
    tick();
    bus.s_ack = 0; bus.s_resp = 1;
    settle();
    chk("rd_m1_resp", 64'(bus.m1_resp), 64'h1);
    chk("rd_m1_rdata", 64'(bus.m1_rdata), 64'hDEAD_BEEF);
    chk("rd_m0_resp", 64'(bus.m0_resp), 64'h0);
    chk("rd_m0_rdata", 64'(bus.m0_rdata), 64'h0);
    tick();
    bus.s_resp = 0;
    settle();
    chk("rd_end_resp", 64'(bus.m1_resp), 64'h0);
    chk("rd_end_rdata", 64'(bus.m1_rdata), 64'h0);
    chk("rd_end_grant", 64'(bus.grant), 64'h0);

    // Spurious s_ack in IDLE, spurious s_resp in WAIT_ACK
    bus.s_ack = 1;
    settle();
    chk("sp_idle_ack", 64'({bus.m1_ack, bus.m0_ack}), 64'h0);
    tick();
    bus.s_ack = 0;
    settle();
    chk("sp_idle_s_req", 64'(bus.s_req), 64'h0);
    chk("sp_idle_grant", 64'(bus.grant), 64'h0);
    bus.m0_req = 1; bus.m0_addr = 32'h30; bus.m0_cmd = 1; bus.m0_wdata = 32'h5A;
    tick();
    bus.s_resp = 1;
    settle();
    chk("sp_wa_resp", 64'({bus.m1_resp, bus.m0_resp}), 64'h0);
    chk("sp_wa_ack", 64'({bus.m1_ack, bus.m0_ack}), 64'h0);
    tick();
    bus.s_resp = 0;
    settle();
    chk("sp_wa_s_req", 64'(bus.s_req), 64'h1);
    chk("sp_wa_grant", 64'(bus.grant), 64'h1);
    chk("sp_wa_s_addr", 64'(bus.s_addr), 64'h30);
    bus.s_ack = 1;
    settle();
    chk("sp_wa_m0_ack", 64'(bus.m0_ack), 64'h1);
    tick();
    bus.s_ack = 0; bus.m0_req = 0;

    // m0 read (single request wins despite pointer), reset while in WAIT_RESP
    bus.m0_req = 1; bus.m0_addr = 32'h40; bus.m0_cmd = 0;
    tick();
    bus.s_ack = 1;
    settle();
    chk("rs_grant", 64'(bus.grant), 64'h1);
    tick();
    bus.s_ack = 0; bus.m0_req = 0;
    rst = 1;
    tick();
    rst = 0;
    settle();
    chk("rs_grant0", 64'(bus.grant), 64'h0);
    chk("rs_s_req0", 64'(bus.s_req), 64'h0);
    chk("rs_fields0", 64'({bus.s_cmd, bus.s_addr, bus.s_wdata}), 64'h0);
    bus.s_resp = 1; bus.s_rdata = 32'h1234_5678;
    settle();
    chk("rs_late_resp", 64'({bus.m1_resp, bus.m0_resp}), 64'h0);
    chk("rs_late_rdata", 64'(bus.m0_rdata), 64'h0);
    tick();
    bus.s_resp = 0;
    bus.m1_req = 1; bus.m1_addr = 32'h50; bus.m1_cmd = 1; bus.m1_wdata = 32'h77;
    tick();
    settle();
    chk("rs_m1_grant", 64'(bus.grant), 64'h2);
    chk("rs_m1_s_req", 64'(bus.s_req), 64'h1);
    chk("rs_m1_s_addr", 64'(bus.s_addr), 64'h50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
